// File: rtl/debounce_pkg.sv
// Shared types and helpers for the debounce FSM: state encoding and counter sizing.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_e;

    // Width of the tick counter; never narrower than one bit.
    function automatic int cnt_width(input int stable_ticks);
        return (stable_ticks < 1) ? 1 : $clog2(stable_ticks + 1);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Parameterized-depth flop chain bringing an asynchronous input into the clk domain.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/debounce_fsm.sv
// Debounce FSM: qualifies a synchronized level change over STABLE_TICKS timer ticks,
// then emits a clean level plus one-cycle rise/fall pulses.
module debounce_fsm
    import debounce_pkg::*;
#(
    parameter int STABLE_TICKS = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic noisy_in,
    input  logic tick,
    output logic timer_en,
    output logic db_level,
    output logic db_rise,
    output logic db_fall
);

    localparam int            CW       = cnt_width(STABLE_TICKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic          sync_in;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          db_level_q, db_level_d;
    logic          db_rise_q, db_rise_d;
    logic          db_fall_q, db_fall_d;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (noisy_in),
        .q_o     (sync_in)
    );

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE_LOW: begin
                if (sync_in) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                // A bounce outranks a coincident tick.
                if (!sync_in) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = IDLE_HIGH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            IDLE_HIGH: begin
                if (!sync_in) begin
                    state_d = WAIT_LOW;
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (sync_in) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = IDLE_LOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered from the next state so they update on the accepting edge.
        db_level_d = (state_d == IDLE_HIGH) || (state_d == WAIT_LOW);
        db_rise_d  = (state_q == WAIT_HIGH) && (state_d == IDLE_HIGH);
        db_fall_d  = (state_q == WAIT_LOW)  && (state_d == IDLE_LOW);
    end

    // NOTE: all control state is reset asynchronously; a reset mid-WAIT simply aborts qualification.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE_LOW;
            cnt_q      <= '0;
            db_level_q <= 1'b0;
            db_rise_q  <= 1'b0;
            db_fall_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            db_level_q <= db_level_d;
            db_rise_q  <= db_rise_d;
            db_fall_q  <= db_fall_d;
        end
    end

    assign timer_en = (state_q == WAIT_HIGH) || (state_q == WAIT_LOW);
    assign db_level = db_level_q;
    assign db_rise  = db_rise_q;
    assign db_fall  = db_fall_q;

endmodule

// File: doc/debounce_fsm.md
# debounce_fsm

Debounce state machine that takes a raw mechanical input (button or switch) and the periodic one-cycle `tick` strobe produced by the upstream saturation timer, and emits a clean level plus single-cycle rise and fall pulses. It sits directly downstream of the timer and drives that timer's `enable` only while a level change is being qualified. Its outputs feed user-input consumers such as counters and mode selectors.

## Interface
- `STABLE_TICKS`, default 8: consecutive ticks the synchronized input must hold a new level before it is accepted; legal range ≥1.
- `SYNC_STAGES`, default 2: synchronizer flop depth; legal range ≥2.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `noisy_in`  in  1  raw asynchronous input.
- `tick`  in  1  one-cycle strobe from the upstream timer's saturation output.
- `timer_en`  out  1  enable for the upstream timer; high in the WAIT states.
- `db_level`  out  1  debounced level.
- `db_rise`  out  1  one-cycle pulse on an accepted 0→1 change.
- `db_fall`  out  1  one-cycle pulse on an accepted 1→0 change.

## Operation
- `noisy_in` passes through a `SYNC_STAGES`-deep flop chain. The output of the chain is `sync_in`. No other logic samples `noisy_in`.
- States: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
- IDLE_LOW:
  - If `sync_in`=1, go to WAIT_HIGH and clear `cnt`.
  - Otherwise stay in IDLE_LOW.
- WAIT_HIGH:
  - If `sync_in`=0, return to IDLE_LOW and clear `cnt`.
  - Else, on `tick`: if `cnt`==STABLE_TICKS-1, go to IDLE_HIGH; otherwise increment `cnt`.
- IDLE_HIGH and WAIT_LOW mirror IDLE_LOW and WAIT_HIGH with the polarity inverted.
- `cnt` width is $clog2(STABLE_TICKS+1). It never exceeds STABLE_TICKS-1 and does not wrap.
- `timer_en` is 1 exactly when the state is WAIT_HIGH or WAIT_LOW.
- The upstream timer has no clear. The tick phase is therefore arbitrary, and acceptance dwell falls between (STABLE_TICKS-1) and STABLE_TICKS tick periods. This is accepted behaviour.
- `db_level`, `db_rise` and `db_fall` are registered outputs:
  - `db_level` = 1 in IDLE_HIGH and WAIT_LOW.
  - `db_rise` = 1 for the single cycle after the WAIT_HIGH→IDLE_HIGH transition edge.
  - `db_fall` is the mirror of `db_rise`.
- Boundary conditions:
  - `tick` and a bounce in the same cycle: the bounce wins. The state returns to IDLE and `cnt` clears.
  - `tick` while in an IDLE state: ignored.
  - Reset mid-WAIT: the FSM aborts. No pulse is emitted.
  - `db_rise` and `db_fall` are never high together.

## Timing
- Reset values:
  - state = IDLE_LOW, `cnt` = 0, all sync flops = 0.
  - `timer_en` = 0, `db_level` = 0, `db_rise` = 0, `db_fall` = 0.
- Input-to-FSM latency: SYNC_STAGES cycles from a `noisy_in` edge to `sync_in`.
- The FSM leaves IDLE one cycle after `sync_in` changes. `timer_en` rises in that same cycle.
- Accept: on the clock edge that samples the qualifying `tick`, the state becomes IDLE_x. In that same cycle `db_level` updates, the matching pulse is 1, and `timer_en` is 0.
- Pulse width is exactly one cycle. At most one pulse occurs per accepted change.
- When `tick` is held high continuously, every cycle counts as a tick. Minimum accept time is then STABLE_TICKS cycles after entering WAIT.

## Structure
- Shared package `debounce_pkg` holds:
  - the state encoding localparams (2-bit: IDLE_LOW=0, WAIT_HIGH=1, IDLE_HIGH=2, WAIT_LOW=3);
  - a width helper for `cnt`.
- Sub-module `sync_ff`: a parameterized-depth synchronizer with async active-low reset to 0. It is instantiated once.
- The FSM, counter and output registers live in `debounce_fsm`, with the next-state logic in a single combinational process.

## Test plan
- Reset: hold `reset_n`=0 with `noisy_in`=1 → all outputs 0. After release, the FSM enters WAIT_HIGH at cycle SYNC_STAGES+1 and `timer_en`=1.
- Clean press (STABLE_TICKS=4, `tick` every 10 cycles, `noisy_in` held 1) → `db_rise` asserts once after the 4th tick, `db_level`=1, `timer_en`=0. No `db_fall`.
- Bounce: toggle `noisy_in` every 7 cycles for 100 cycles, then hold 0 → no pulses, `db_level` stays 0, and `timer_en` drops after the last bounce clears.
- Simultaneous: drive `sync_in`→0 in the same cycle as the 4th `tick` while in WAIT_HIGH → state returns to IDLE_LOW, no `db_rise`.
- Release after press: `noisy_in` 1→0 held 5 ticks → exactly one `db_fall`, `db_level`=0.
- Reset mid-WAIT after 2 ticks → outputs 0, no pulse, FSM in IDLE_LOW.
